// File: rtl/dcache_pkg.sv
// Shared types and sizes for the data-cache miss/fill path.
// Address layout is {tag[31:14], index[13:6], offset[5:0]} with 16-byte beats.
package dcache_pkg;

  localparam int TAG_W  = 18;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = 6;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    WB_READ,
    WB_REQ,
    WB_SEND,
    FILL_REQ,
    FILL_DATA,
    DONE
  } mh_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } dc_addr_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] index);
    return {tag, index, {OFF_W{1'b0}}};
  endfunction

  function automatic logic [OFF_W-1:0] beat_line(input logic [BEAT_W-1:0] beat);
    return {beat, 4'b0000};
  endfunction

endpackage

// File: rtl/dcache_miss_handler_if.sv
// Miss request, cache-array and memory-side signals of the miss handler.
// master = the miss handler, slave = cache array / memory environment.
interface dcache_miss_handler_if;
  import dcache_pkg::*;

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic [1:0]        miss_way;
  logic              miss_dirty;
  logic [TAG_W-1:0]  victim_tag;

  logic              c_r;
  logic [IDX_W-1:0]  c_r_index;
  logic [OFF_W-1:0]  c_r_line;
  logic              c_no_tagcheck_read;
  logic [1:0]        c_no_tagcheck_way;
  logic [DATA_W-1:0] c_data_out;

  logic              c_w;
  logic [IDX_W-1:0]  c_w_index;
  logic [TAG_W-1:0]  c_w_tag;
  logic [OFF_W-1:0]  c_w_line;
  logic [1:0]        c_w_way;
  logic [DATA_W-1:0] c_w_data;
  logic              c_last_write_from_mem;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_done;

  modport master (
    input  miss_valid, miss_addr, miss_way, miss_dirty, victim_tag, c_data_out,
           mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    output miss_ready, c_r, c_r_index, c_r_line, c_no_tagcheck_read, c_no_tagcheck_way,
           c_w, c_w_index, c_w_tag, c_w_line, c_w_way, c_w_data, c_last_write_from_mem,
           mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata, fill_done
  );

  modport slave (
    output miss_valid, miss_addr, miss_way, miss_dirty, victim_tag, c_data_out,
           mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    input  miss_ready, c_r, c_r_index, c_r_line, c_no_tagcheck_read, c_no_tagcheck_way,
           c_w, c_w_index, c_w_tag, c_w_line, c_w_way, c_w_data, c_last_write_from_mem,
           mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata, fill_done
  );

endinterface

// File: rtl/dcache_line_buffer.sv
// Victim line holding store: one write port per beat, combinational read, no reset on data.
// Latency: write visible the cycle after wr_en; no backpressure.
module dcache_line_buffer
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [BEATS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_beat] <= wr_data;
  end

  assign rd_data = mem[rd_beat];

endmodule

// File: rtl/dcache_miss_handler.sv
// Miss/fill controller: optional 4-beat victim writeback, then 4-beat line fill into the victim way.
// Request on cycle after accept (clean) or after 5 read cycles (dirty); req/wdata hold under unbounded stalls.
module dcache_miss_handler
  import dcache_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  dcache_miss_handler_if.master bus
);

  mh_state_t         state;
  logic [BEAT_W-1:0] cnt;
  logic              cap_vld;
  logic [TAG_W-1:0]  lat_tag;
  logic [TAG_W-1:0]  lat_vtag;
  logic [IDX_W-1:0]  lat_idx;
  logic [1:0]        lat_way;
  dc_addr_t          req_addr;

  logic              buf_we;
  logic [BEAT_W-1:0] buf_rd_beat;
  logic [DATA_W-1:0] buf_rd_data;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  assign req_addr    = dc_addr_t'(bus.miss_addr);
  // Captures trail the read strobe by one cycle, so cnt doubles as the capture beat.
  assign buf_we      = (state == WB_READ) && cap_vld;
  // Pre-select the next beat so mem_wdata can be reloaded on the accepting edge.
  assign buf_rd_beat = (state == WB_SEND) ? BEAT_W'(cnt + 1'b1) : '0;

  dcache_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_beat (cnt),
    .wr_data (bus.c_data_out),
    .rd_beat (buf_rd_beat),
    .rd_data (buf_rd_data)
  );

  assign bus.c_no_tagcheck_read = bus.c_r;
  assign bus.c_no_tagcheck_way  = lat_way;
  assign bus.c_r_index          = lat_idx;
  assign bus.c_w_index          = lat_idx;
  assign bus.c_w_tag            = lat_tag;
  assign bus.c_w_way            = lat_way;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                     <= IDLE;
      cnt                       <= '0;
      cap_vld                   <= 1'b0;
      lat_tag                   <= '0;
      lat_vtag                  <= '0;
      lat_idx                   <= '0;
      lat_way                   <= '0;
      bus.miss_ready            <= 1'b1;
      bus.c_r                   <= 1'b0;
      bus.c_r_line              <= '0;
      bus.c_w                   <= 1'b0;
      bus.c_w_line              <= '0;
      bus.c_w_data              <= '0;
      bus.c_last_write_from_mem <= 1'b0;
      bus.mem_req_valid         <= 1'b0;
      bus.mem_req_we            <= 1'b0;
      bus.mem_req_addr          <= '0;
      bus.mem_wvalid            <= 1'b0;
      bus.mem_wdata             <= '0;
      bus.fill_done             <= 1'b0;
    end else begin
      bus.c_w                   <= 1'b0;
      bus.c_last_write_from_mem <= 1'b0;
      bus.fill_done             <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            lat_tag        <= req_addr.tag;
            lat_idx        <= req_addr.index;
            lat_way        <= bus.miss_way;
            lat_vtag       <= bus.victim_tag;
            bus.miss_ready <= 1'b0;
            cnt            <= '0;
            cap_vld        <= 1'b0;
            if (bus.miss_dirty) begin
              state        <= WB_READ;
              bus.c_r      <= 1'b1;
              bus.c_r_line <= beat_line('0);
            end else begin
              state             <= FILL_REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b0;
              bus.mem_req_addr  <= line_addr(req_addr.tag, req_addr.index);
            end
          end
        end
        WB_READ: begin
          cap_vld <= bus.c_r;
          if (bus.c_r && bus.c_r_line[5:4] != LAST_BEAT) begin
            bus.c_r_line <= beat_line(BEAT_W'(bus.c_r_line[5:4] + 1'b1));
          end else begin
            bus.c_r      <= 1'b0;
            bus.c_r_line <= '0;
          end
          if (cap_vld) begin
            if (cnt == LAST_BEAT) begin
              state             <= WB_REQ;
              cnt               <= '0;
              cap_vld           <= 1'b0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b1;
              bus.mem_req_addr  <= line_addr(lat_vtag, lat_idx);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WB_REQ: begin
          if (bus.mem_req_ready) begin
            state             <= WB_SEND;
            cnt               <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_we    <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_wvalid    <= 1'b1;
            bus.mem_wdata     <= buf_rd_data;
          end
        end
        WB_SEND: begin
          if (bus.mem_wready) begin
            if (cnt == LAST_BEAT) begin
              state             <= FILL_REQ;
              cnt               <= '0;
              bus.mem_wvalid    <= 1'b0;
              bus.mem_wdata     <= '0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b0;
              bus.mem_req_addr  <= line_addr(lat_tag, lat_idx);
            end else begin
              cnt           <= cnt + 1'b1;
              bus.mem_wdata <= buf_rd_data;
            end
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_ready) begin
            state             <= FILL_DATA;
            cnt               <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
          end
        end
        FILL_DATA: begin
          if (bus.mem_rvalid) begin
            bus.c_w      <= 1'b1;
            bus.c_w_line <= beat_line(cnt);
            bus.c_w_data <= bus.mem_rdata;
            if (cnt == LAST_BEAT) begin
              state                     <= DONE;
              cnt                       <= '0;
              bus.c_last_write_from_mem <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          cnt            <= '0;
          bus.fill_done  <= 1'b1;
          bus.miss_ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.miss_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Scoreboard bench: per-miss expectations from a line-level model; responders emulate cache array and memory.
module tb_dcache_miss_handler;
  import dcache_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } req_t;

  typedef struct packed {
    logic [5:0]   line;
    logic [1:0]   way;
    logic [7:0]   idx;
    logic [17:0]  tag;
    logic         last;
    logic [127:0] data;
  } cw_t;

  logic clk;
  logic rst;
  dcache_miss_handler_if bus ();

  dcache_miss_handler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  req_t         exp_req[$];
  logic [127:0] exp_wd[$];
  cw_t          exp_cw[$];
  logic [127:0] fill_q[$];
  int           exp_done = 0;

  int rand_mode = 0;
  int rv_gap = 0;
  int extra_pulses = 0;
  int stall_beat = -1;
  int stall_len = 0;
  bit rv_busy = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cache array contents: distinct, position-dependent words per (way, index, beat).
  function automatic logic [127:0] cword(input logic [1:0] w, input logic [7:0] i, input logic [1:0] b);
    logic [31:0] k;
    k = {20'hD0C0A, w, i, b};
    return {k, k ^ 32'h5A5A_1234, ~k, k + 32'h0101_0101};
  endfunction

  // Cache array read port: data one cycle after the strobe, junk otherwise.
  initial begin
    logic       cr;
    logic [1:0] w;
    logic [7:0] i;
    logic [5:0] l;
    bus.c_data_out = '0;
    forever begin
      @(negedge clk);
      cr = bus.c_r; w = bus.c_no_tagcheck_way; i = bus.c_r_index; l = bus.c_r_line;
      tick();
      bus.c_data_out = cr ? cword(w, i, l[5:4]) : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    bus.mem_req_ready = 1'b0;
    forever begin
      tick();
      bus.mem_req_ready = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit hs;
    int wb_cnt;
    int stall_left;
    wb_cnt = 0;
    stall_left = 0;
    bus.mem_wready = 1'b0;
    forever begin
      @(negedge clk);
      hs = rst && bus.mem_wvalid && bus.mem_wready;
      tick();
      if (!rst) wb_cnt = 0;
      if (hs) begin
        wb_cnt = (wb_cnt + 1) % 4;
        if (wb_cnt == stall_beat) stall_left = stall_len;
      end
      if (stall_left > 0) begin
        bus.mem_wready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_wready = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Memory read side: four fill beats after each accepted fill request, then optional stray pulses.
  initial begin
    bit hs;
    int g;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = rst && bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we;
      tick();
      if (hs) begin
        rv_busy = 1;
        for (int b = 0; b < 4; b++) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = (fill_q.size() > 0) ? fill_q.pop_front() : '0;
          tick();
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
          g = (rand_mode != 0) ? $urandom_range(0, 2) : rv_gap;
          repeat (g) tick();
        end
        for (int e = 0; e < extra_pulses; e++) begin
          bus.mem_rvalid = 1'b1;
          tick();
          bus.mem_rvalid = 1'b0;
          tick();
        end
        rv_busy = 0;
      end
    end
  end

  // Monitor: everything seen here will be sampled by the next rising edge.
  initial begin
    bit           req_hold = 0;
    bit           wd_hold = 0;
    bit           pend_done = 0;
    logic [32:0]  held_req;
    logic [127:0] held_wd;
    req_t         er;
    cw_t          ec;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_hold = 0; wd_hold = 0; pend_done = 0;
      end else begin
        if (req_hold)
          chk("req_hold", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr}, {1'b1, held_req});
        if (wd_hold)
          chk("wdata_hold", {bus.mem_wvalid, bus.mem_wdata}, {1'b1, held_wd});
        if (pend_done) chk("fill_done_lat", bus.fill_done, 1'b1);
        req_hold  = bus.mem_req_valid && !bus.mem_req_ready;
        held_req  = {bus.mem_req_we, bus.mem_req_addr};
        wd_hold   = bus.mem_wvalid && !bus.mem_wready;
        held_wd   = bus.mem_wdata;
        pend_done = bus.c_w && bus.c_last_write_from_mem;

        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (exp_req.size() == 0) chk("unexpected_req", {bus.mem_req_we, bus.mem_req_addr}, 'x);
          else begin
            er = exp_req.pop_front();
            chk("mem_req", {bus.mem_req_we, bus.mem_req_addr}, {er.we, er.addr});
          end
        end
        if (bus.mem_wvalid && bus.mem_wready) begin
          if (exp_wd.size() == 0) chk("unexpected_wbeat", bus.mem_wdata, 'x);
          else chk("mem_wdata", bus.mem_wdata, exp_wd.pop_front());
        end
        if (bus.c_w) begin
          if (exp_cw.size() == 0) chk("unexpected_c_w", bus.c_w_line, 'x);
          else begin
            ec = exp_cw.pop_front();
            chk("c_w_ctl", {bus.c_w_line, bus.c_w_way, bus.c_w_index, bus.c_w_tag, bus.c_last_write_from_mem},
                {ec.line, ec.way, ec.idx, ec.tag, ec.last});
            chk("c_w_data", bus.c_w_data, ec.data);
          end
        end
        if (bus.c_r || bus.c_w) chk("r_w_exclusive", bus.c_r && bus.c_w, 1'b0);
        if (bus.fill_done) begin
          chk("fill_done_expected", exp_done > 0, 1'b1);
          if (exp_done > 0) exp_done--;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miss_ready"}, bus.miss_ready, 1'b1);
    chk({tag, "_mem_req"}, {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr}, '0);
    chk({tag, "_mem_w"}, {bus.mem_wvalid, bus.mem_wdata}, '0);
    chk({tag, "_c_r"}, {bus.c_r, bus.c_no_tagcheck_read, bus.c_r_index, bus.c_r_line, bus.c_no_tagcheck_way}, '0);
    chk({tag, "_c_w"}, {bus.c_w, bus.c_w_index, bus.c_w_tag, bus.c_w_line, bus.c_w_way, bus.c_last_write_from_mem}, '0);
    chk({tag, "_c_w_data"}, bus.c_w_data, '0);
    chk({tag, "_fill_done"}, bus.fill_done, 1'b0);
  endtask

  // Reference model for one miss, then drives the request and checks request latency.
  task automatic issue_miss(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                            input logic [17:0] vtag, input int nwr);
    logic [7:0]   idx;
    logic [17:0]  tag;
    logic [127:0] d;
    int           n;
    idx = addr[13:6];
    tag = addr[31:14];
    if (dirty) begin
      exp_req.push_back('{we: 1'b1, addr: {vtag, idx, 6'b0}});
      for (int b = 0; b < 4; b++) exp_wd.push_back(cword(way, idx, 2'(b)));
    end
    exp_req.push_back('{we: 1'b0, addr: {tag, idx, 6'b0}});
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      fill_q.push_back(d);
      if (b < nwr)
        exp_cw.push_back('{line: 6'(b * 16), way: way, idx: idx, tag: tag, last: (b == 3), data: d});
    end
    if (nwr == 4) exp_done++;

    tick();
    bus.miss_valid = 1'b1; bus.miss_addr = addr; bus.miss_way = way;
    bus.miss_dirty = dirty; bus.victim_tag = vtag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.miss_ready && n < 2000);
    if (n >= 2000) chk("miss_accept_timeout", 1'b0, 1'b1);
    tick();
    bus.miss_valid = 1'b0; bus.miss_addr = $urandom; bus.miss_dirty = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req_valid && n < 50);
    chk("req_latency", n, dirty ? 6 : 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_wd.size() != 0 || exp_cw.size() != 0 || exp_done != 0 ||
            rv_busy || !bus.miss_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({name, "_idle_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_cw(input logic [5:0] line, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.c_w && bus.c_w_line == line) && n < 500);
    if (n >= 500) chk({name, "_cw_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_way = '0;
    bus.miss_dirty = 1'b0; bus.victim_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Clean miss, immediate ready, back-to-back fill beats.
    issue_miss(32'h1234_5680, 2'd2, 1'b0, 18'h0, 4);
    wait_idle("clean");

    // Dirty miss with the all-ones victim tag.
    issue_miss(32'hA5C3_1E40, 2'd1, 1'b1, 18'h3FFFF, 4);
    wait_idle("dirty");

    // Dirty miss with a three-cycle write stall on beat 1.
    stall_beat = 1; stall_len = 3;
    issue_miss(32'h0F0F_3AC0, 2'd3, 1'b1, 18'h2_1357, 4);
    wait_idle("wstall");
    stall_beat = -1; stall_len = 0;

    // New miss offered mid-fill is ignored.
    rv_gap = 2;
    issue_miss(32'h7654_3210, 2'd0, 1'b0, 18'h0, 4);
    wait_cw(6'h00, "busy");
    tick();
    bus.miss_valid = 1'b1; bus.miss_addr = 32'hDEAD_BEC0; bus.miss_dirty = 1'b1;
    @(negedge clk);
    chk("busy_miss_ready", bus.miss_ready, 1'b0);
    tick();
    bus.miss_valid = 1'b0;
    wait_idle("busy");
    repeat (10) tick();

    // Reset after fill beat 2 is written: abandon, no final write.
    rv_gap = 3;
    issue_miss(32'h1357_9BC0, 2'd1, 1'b0, 18'h0, 3);
    wait_cw(6'h20, "abort");
    tick();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst = 1'b1;
    wait_idle("abort");
    rv_gap = 0;
    issue_miss(32'h2468_ACC0, 2'd3, 1'b1, 18'h1_0203, 4);
    wait_idle("post_rst");

    // Gapped fill beats followed by stray rvalid pulses.
    rv_gap = 2; extra_pulses = 5;
    issue_miss(32'hCAFE_F00D, 2'd2, 1'b0, 18'h0, 4);
    wait_idle("gapped");
    rv_gap = 0; extra_pulses = 0;

    rand_mode = 1;
    for (int k = 0; k < 20; k++) begin
      issue_miss($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 18'($urandom), 4);
      wait_idle("random");
    end
    rand_mode = 0;

    repeat (20) tick();
    chk("end_req_q", exp_req.size(), 0);
    chk("end_wd_q", exp_wd.size(), 0);
    chk("end_cw_q", exp_cw.size(), 0);
    chk("end_done", exp_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_miss_handler.md
# dcache_miss_handler

Miss/fill controller sitting between the data cache array and the memory interface. On a tag-check miss it captures the line address, victim way and victim tag. If the victim is dirty it reads the 4-beat (4×128-bit) victim line out of the cache and writes it back to memory. It then fetches the missing line from memory, writes it into the victim way beat by beat, and marks it valid with `c_last_write_from_mem` on the final beat.

## Interface
- `TAG_W`, 18, tag width
- `IDX_W`, 8, set index width
- `DATA_W`, 128, beat width
- `BEATS`, 4, beats per line (line = 64 B, beat select = addr[5:4])
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `miss_valid`  in  1  miss request; accepted when `miss_ready`=1
- `miss_ready`  out  1  high only in IDLE
- `miss_addr`  in  32  {tag[31:14], index[13:6], offset[5:0]}
- `miss_way`  in  2  victim way
- `miss_dirty`  in  1  victim dirty
- `victim_tag`  in  TAG_W  victim tag, used for writeback address
- `c_r`  out  1  no-tagcheck cache read strobe
- `c_r_index`  out  IDX_W  read index
- `c_r_line`  out  6  read line; only bits [5:4] are significant
- `c_no_tagcheck_read`  out  1  equals `c_r`
- `c_no_tagcheck_way`  out  2  latched victim way
- `c_data_out`  in  DATA_W  cache read data, valid 1 cycle after `c_r`
- `c_w`  out  1  cache write strobe
- `c_w_index`  out  IDX_W  write index
- `c_w_tag`  out  TAG_W  write tag
- `c_w_line`  out  6  write line
- `c_w_way`  out  2  write way
- `c_w_data`  out  DATA_W  write data
- `c_last_write_from_mem`  out  1  high with the final fill beat
- `mem_req_valid`  out  1  line request
- `mem_req_ready`  in  1  request accepted
- `mem_req_we`  out  1  1 = writeback, 0 = fill
- `mem_req_addr`  out  32  line-aligned; [5:0]=0
- `mem_wvalid`  out  1  writeback beat valid
- `mem_wready`  in  1  writeback beat accepted
- `mem_wdata`  out  DATA_W  writeback beat
- `mem_rvalid`  in  1  fill beat valid (no backpressure)
- `mem_rdata`  in  DATA_W  fill beat
- `fill_done`  out  1  one-cycle pulse when the line has been installed

## Operation
- States: IDLE, WB_READ, WB_REQ, WB_SEND, FILL_REQ, FILL_DATA, DONE.
- IDLE: on `miss_valid`, latch addr/way/dirty/victim_tag. Go to WB_READ if dirty, else FILL_REQ.
- WB_READ: issue `c_r` for beats 0..3 on 4 consecutive cycles. Capture `c_data_out` one cycle later into the line buffer. Go to WB_REQ after beat 3 is captured.
- WB_REQ: assert `mem_req_valid`, `mem_req_we`=1, address {victim_tag, index, 6'b0}. Hold until `mem_req_ready`, then go to WB_SEND.
- WB_SEND: present beat k on `mem_wdata` with `mem_wvalid`. Advance k on `mem_wready`; data stays stable while stalled. Go to FILL_REQ after beat 3 is accepted.
- FILL_REQ: assert `mem_req_valid`, `mem_req_we`=0, address {tag, index, 6'b0}. Go to FILL_DATA on `mem_req_ready`.
- FILL_DATA: each `mem_rvalid` beat k produces a cache write the next cycle: `c_w`=1, `c_w_line`={k[1:0],4'b0}, latched way/index/tag. Beat 3 also asserts `c_last_write_from_mem`. Then go to DONE.
- DONE: `fill_done`=1 for one cycle, then IDLE.
- Beat counter is 2 bits and clears on every state entry.

## Timing
- Reset: all outputs 0 except `miss_ready`=1; state IDLE; counters and buffers 0.
- Reset asserted mid-operation: abandon immediately and return to IDLE next edge. Partial fills leave the way invalid, because `c_last_write_from_mem` was never issued.
- Clean miss: accept edge T; `mem_req_valid` from T+1. The first fill write is the cycle after the first `mem_rvalid`. `fill_done` is the cycle after the last write.
- Dirty miss adds 5 cycles of WB_READ, plus request and beat handshakes.
- `miss_valid` while busy is ignored. `mem_rvalid` outside FILL_DATA or beyond beat 3 is ignored.
- `mem_req_valid`, `mem_req_addr` and `mem_req_we` stay stable until the ready handshake. Stalls are unbounded.
- `c_r` and `c_w` are never high in the same cycle.

## Structure
- `dcache_pkg`:
  - state enum `mh_state_t`
  - `TAG_W`, `IDX_W`, `DATA_W`, `BEATS`
  - packed struct `dc_addr_t` {tag, index, offset}
- Sub-module `dcache_line_buffer`: BEATS×DATA_W register file with a write port (beat, data, en) and a combinational read by beat; no reset on data.

## Test plan
- Clean miss, addr 0x1234_5680, way 2, `mem_req_ready` immediate, `mem_rvalid` 4 back-to-back beats A0..A3:
  - fill request at addr 0x1234_5680;
  - 4 `c_w` writes to lines 0x00/0x10/0x20/0x30, way 2, index 0x5A;
  - `c_last_write_from_mem` only on the 4th write;
  - `fill_done` one cycle later.
- Dirty miss, victim_tag 0x3FFFF, way 1: cache returns D0..D3 → request `mem_req_we`=1 at addr {0x3FFFF, idx, 0}; `mem_wdata` D0..D3 in order; then the fill proceeds.
- `mem_wready` low 3 cycles on beat 1 → `mem_wdata`=D1 held, `mem_wvalid` held; no beat skipped or duplicated.
- `miss_valid` pulsed during FILL_DATA → ignored; `miss_ready`=0; exactly one `fill_done`.
- `rst`=0 after fill beat 2 → next cycle all outputs reset, IDLE; `c_last_write_from_mem` never asserted. A fresh miss then completes normally.
- Gapped `mem_rvalid` (beat, 2 idle cycles, beat …) → writes track the beats one cycle late; 5 extra `mem_rvalid` pulses after DONE produce no `c_w`.
